// File: rtl/parity_pkg.sv
// Shared definitions for the parity arbiter: word width, FSM encoding, round-robin helper.
package parity_pkg;

  localparam int unsigned WORD_W = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Next index in round-robin order, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/parity_core.sv
// Combinational parity of one word (1 = odd number of ones).
module parity_core
  import parity_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic              parity_c
);

  // XOR reduction of the word
  assign parity_c = ^word;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one parity core among NREQ requesters, with a
// registered, backpressured result channel and a saturating odd-parity counter.
module parity_arbiter
  import parity_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ),
  parameter int unsigned CNTW = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [WORD_W*NREQ-1:0] req_word,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out_word,
  output logic [IDW-1:0]         out_id,
  output logic                   out_parity,
  output logic [CNTW-1:0]        odd_cnt
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic [IDW-1:0]    out_id_q, out_id_d;
  logic              out_parity_q, out_parity_d;
  logic [CNTW-1:0]   odd_cnt_q, odd_cnt_d;

  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic              grant_en;
  logic              accept;
  logic [WORD_W-1:0] grant_word;
  logic              grant_parity;

  // Priority search starting at ptr and wrapping; depends only on valids and ptr
  always_comb begin
    logic [IDW:0] sum;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!win_found && req_valid[IDW'(sum)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(sum);
      end
    end
  end

  // Grant is possible when idle, or when the held result drains this cycle
  always_comb begin
    grant_en  = (state_q == ST_IDLE) || out_ready;
    req_ready = '0;
    if (grant_en && win_found) req_ready = NREQ'(1) << win_idx;
    accept    = |req_ready;
  end

  // Select the granted requester's word for the shared parity core
  always_comb begin
    grant_word = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IDW'(k) == win_idx) grant_word = req_word[k*WORD_W +: WORD_W];
    end
  end

  parity_core u_core (
    .word     (grant_word),
    .parity_c (grant_parity)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: BUSY while a result is held, back to IDLE when it drains with no new word
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (out_ready && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: latch on accept, drop valid on drain
  always_comb begin
    ptr_d        = ptr_q;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    out_id_d     = out_id_q;
    out_parity_d = out_parity_q;
    odd_cnt_d    = odd_cnt_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_word_d   = grant_word;
      out_id_d     = win_idx;
      out_parity_d = grant_parity;
      ptr_d        = IDW'(rr_next(32'(win_idx), NREQ));
      if (grant_parity && (odd_cnt_q != {CNTW{1'b1}})) odd_cnt_d = odd_cnt_q + CNTW'(1);
    end else if ((state_q == ST_BUSY) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      out_id_q     <= '0;
      out_parity_q <= 1'b0;
      odd_cnt_q    <= '0;
    end else begin
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      out_id_q     <= out_id_d;
      out_parity_q <= out_parity_d;
      odd_cnt_q    <= odd_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign out_id     = out_id_q;
  assign out_parity = out_parity_q;
  assign odd_cnt    = odd_cnt_q;

endmodule

// File: tb/tb_parity_arbiter.sv
// Bench for parity_arbiter: directed vector table, saturation and reset sequences,
// then randomized traffic against a behavioural model with a result scoreboard.
module tb_parity_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned CNTW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid, req_ready;
  logic [7*NREQ-1:0] req_word;
  logic              out_valid, out_ready, out_parity;
  logic [6:0]        out_word;
  logic [IDW-1:0]    out_id;
  logic [CNTW-1:0]   odd_cnt;

  logic [NREQ-1:0]   s_req_valid, s_req_ready;
  logic [7*NREQ-1:0] s_req_word;
  logic              s_out_valid, s_out_ready, s_out_parity;
  logic [6:0]        s_out_word;
  logic [IDW-1:0]    s_out_id;
  logic [1:0]        s_odd_cnt;

  parity_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_word(req_word),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_id(out_id), .out_parity(out_parity), .odd_cnt(odd_cnt)
  );

  parity_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .req_valid(s_req_valid), .req_word(s_req_word),
    .req_ready(s_req_ready), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_word(s_out_word), .out_id(s_out_id), .out_parity(s_out_parity), .odd_cnt(s_odd_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [27:0] words;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_id;
    logic [6:0]  exp_word;
    logic        exp_par;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [27:0] w, input logic r,
                              input logic [3:0] er, input logic eov, input logic [1:0] eid,
                              input logic [6:0] ew, input logic ep, input logic [7:0] ec);
    vec_t t;
    t.valid = v; t.words = w; t.ordy = r; t.exp_rdy = er; t.exp_ov = eov;
    t.exp_id = eid; t.exp_word = ew; t.exp_par = ep; t.exp_cnt = ec;
    return t;
  endfunction

  // Behavioural model state
  bit         m_busy;
  int         m_ptr;
  logic [6:0] m_word;
  int         m_id;
  int         m_par;
  int         m_cnt;
  int         sb_q[$];

  function automatic int winner(input logic [3:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [6:0] word_of(input logic [27:0] w, input int i);
    logic [27:0] s;
    s = w >> (7 * i);
    return s[6:0];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_word = '0; m_id = 0; m_par = 0; m_cnt = 0;
    sb_q.delete();
  endtask

  logic [27:0] w_a, w_b;

  initial begin
    reset_n = 1'b0;
    req_valid = '0; req_word = '0; out_ready = 1'b0;
    s_req_valid = '0; s_req_word = '0; s_out_ready = 1'b0;
    w_a = {7'h7F, 7'h07, 7'h03, 7'h01};
    w_b = {7'h7F, 7'h07, 7'h03, 7'h55};

    // Reset state
    #12;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_word", 32'(out_word), 0);
    check("reset_out_id", 32'(out_id), 0);
    check("reset_out_parity", 32'(out_parity), 0);
    check("reset_odd_cnt", 32'(odd_cnt), 0);
    check("reset_req_ready", 32'(req_ready), 0);
    @(posedge clk); #2;
    reset_n = 1'b1;

    // Idle for 10 cycles
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      check("idle_out_valid", 32'(out_valid), 0);
      check("idle_req_ready", 32'(req_ready), 0);
    end

    // Saturating counter with CNTW=2: five odd words
    s_req_valid = 4'b0001; s_req_word = 28'h1; s_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      check("sat_odd_cnt", 32'(s_odd_cnt), (k + 1 > 3) ? 3 : k + 1);
    end
    s_req_valid = '0;

    // Directed table: round robin, single request, backpressure, drain
    vecs.push_back(mk(4'b1111, w_a, 1, 4'b0001, 1, 0, 7'h01, 1, 1));
    vecs.push_back(mk(4'b1111, w_a, 1, 4'b0010, 1, 1, 7'h03, 0, 1));
    vecs.push_back(mk(4'b1111, w_a, 1, 4'b0100, 1, 2, 7'h07, 1, 2));
    vecs.push_back(mk(4'b1111, w_a, 1, 4'b1000, 1, 3, 7'h7F, 1, 3));
    vecs.push_back(mk(4'b1111, w_a, 1, 4'b0001, 1, 0, 7'h01, 1, 4));
    vecs.push_back(mk(4'b0000, w_a, 1, 4'b0000, 0, 0, 7'h00, 0, 4));
    vecs.push_back(mk(4'b0001, w_b, 1, 4'b0001, 1, 0, 7'h55, 0, 4));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(4'b1111, w_b, 0, 4'b0000, 1, 0, 7'h55, 0, 4));
    vecs.push_back(mk(4'b0100, w_b, 1, 4'b0100, 1, 2, 7'h07, 1, 5));
    vecs.push_back(mk(4'b0000, w_b, 1, 4'b0000, 0, 0, 7'h00, 0, 5));

    @(posedge clk); #2;
    foreach (vecs[i]) begin
      req_valid = vecs[i].valid; req_word = vecs[i].words; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #2;
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d_odd_cnt", i), 32'(odd_cnt), 32'(vecs[i].exp_cnt));
      if (vecs[i].exp_ov) begin
        check($sformatf("vec%0d_out_id", i), 32'(out_id), 32'(vecs[i].exp_id));
        check($sformatf("vec%0d_out_word", i), 32'(out_word), 32'(vecs[i].exp_word));
        check($sformatf("vec%0d_out_parity", i), 32'(out_parity), 32'(vecs[i].exp_par));
      end
    end
    req_valid = '0;

    // Fresh reset, then randomized traffic against the model
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      int w;
      bit ge;
      logic [3:0] exp_rdy;
      req_valid = 4'($urandom);
      req_word  = 28'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ge = !m_busy || out_ready;
      w = winner(req_valid, m_ptr);
      exp_rdy = (ge && w >= 0) ? 4'(1 << w) : 4'b0000;
      #1;
      check("rand_req_ready", 32'(req_ready), 32'(exp_rdy));
      if (m_busy && out_ready) begin
        if (sb_q.size() == 0) begin
          check("rand_sb_unexpected_result", 1, 0);
        end else begin
          int e;
          e = sb_q.pop_front();
          check("rand_sb_result", {23'b0, out_id, out_word}, 32'(e));
        end
      end
      @(posedge clk);
      if (ge && w >= 0) begin
        m_word = word_of(req_word, w);
        m_id   = w;
        m_par  = $countones(m_word) % 2;
        m_ptr  = (w + 1) % NREQ;
        m_busy = 1;
        if (m_cnt < 255) m_cnt = m_cnt + m_par;
        sb_q.push_back((w << 7) | int'(m_word));
      end else if (m_busy && out_ready) begin
        m_busy = 0;
      end
      #2;
      check("rand_out_valid", 32'(out_valid), 32'(m_busy));
      check("rand_odd_cnt", 32'(odd_cnt), 32'(m_cnt));
      if (m_busy) begin
        check("rand_out_word", 32'(out_word), 32'(m_word));
        check("rand_out_id", 32'(out_id), 32'(m_id));
        check("rand_out_parity", 32'(out_parity), 32'(m_par));
      end
    end

    // Reset mid-operation: become BUSY under backpressure, then assert reset between edges
    req_valid = 4'b0001; req_word = {21'b0, 7'h01}; out_ready = 1'b0;
    @(posedge clk); #2;
    check("midrst_busy_before", 32'(out_valid), 1);
    req_valid = '0;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_odd_cnt", 32'(odd_cnt), 0);
    check("midrst_out_word", 32'(out_word), 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    req_valid = 4'b1000; req_word = {7'h07, 21'b0}; out_ready = 1'b1;
    #1;
    check("postrst_req_ready", 32'(req_ready), 32'(4'b1000));
    @(posedge clk); #2;
    check("postrst_out_valid", 32'(out_valid), 1);
    check("postrst_out_id", 32'(out_id), 3);
    check("postrst_out_word", 32'(out_word), 32'(7'h07));
    check("postrst_odd_cnt", 32'(odd_cnt), 1);
    req_valid = '0;
    @(posedge clk); #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
